// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element MAC controller: the FSM
// state encoding and the counter-width helper.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pe_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-accumulate: signed a*b, sign-extended to the
// accumulator width, added to acc_in with modulo wrap.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [PSUM_WIDTH-1:0] acc_in,
  output logic signed [PSUM_WIDTH-1:0] acc_out
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  // Widen the full-precision product to the accumulator width keeping its sign.
  function automatic logic signed [PSUM_WIDTH-1:0] sext_prod(
    input logic signed [2*DATA_WIDTH-1:0] p
  );
    logic signed [PSUM_WIDTH-1:0] r;
    r = p;
    return r;
  endfunction

  // Product and accumulate; the sum wraps naturally at PSUM_WIDTH bits.
  always_comb begin
    prod    = a * b;
    acc_out = acc_in + sext_prod(prod);
  end

endmodule

// File: rtl/pe_mac_ctrl.sv
// PE compute stage: pops ifmap/filter word pairs, accumulates FILT_LEN
// products into one psum, pushes it to the psum FIFO, NUM_OUT times per start.
module pe_mac_ctrl
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 32,
  parameter int FILT_LEN   = 3,
  parameter int NUM_OUT    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  ifmap_empty,
  input  logic [DATA_WIDTH-1:0] ifmap_data,
  output logic                  ifmap_ren,
  input  logic                  filt_empty,
  input  logic [DATA_WIDTH-1:0] filt_data,
  output logic                  filt_ren,
  input  logic                  psum_full,
  output logic                  psum_wen,
  output logic [PSUM_WIDTH-1:0] psum_din,
  output logic                  busy,
  output logic                  done
);

  localparam int KW = cnt_width(FILT_LEN);
  localparam int OW = cnt_width(NUM_OUT);
  localparam logic [KW-1:0] K_LAST = KW'(FILT_LEN - 1);
  localparam logic [OW-1:0] O_LAST = OW'(NUM_OUT - 1);

  pe_state_t                  state, state_n;
  logic signed [PSUM_WIDTH-1:0] acc, acc_n, mac_out;
  logic [KW-1:0]              k_cnt, k_n;
  logic [OW-1:0]              o_cnt, o_n;
  logic                       fire, push;

  pe_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .PSUM_WIDTH (PSUM_WIDTH)
  ) u_mac (
    .a       (signed'(ifmap_data)),
    .b       (signed'(filt_data)),
    .acc_in  (acc),
    .acc_out (mac_out)
  );

  // State, accumulator and counters; reset and clear both return to an empty IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      acc   <= '0;
      k_cnt <= '0;
      o_cnt <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      k_cnt <= k_n;
      o_cnt <= o_n;
    end
  end

  // Next-state and FIFO handshakes; clear overrides everything and blocks pops/pushes.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    k_n     = k_cnt;
    o_n     = o_cnt;
    fire    = 1'b0;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = MAC;
          acc_n   = '0;
          k_n     = '0;
          o_n     = '0;
        end
      end
      MAC: begin
        fire = !ifmap_empty && !filt_empty;
        if (fire) begin
          acc_n = mac_out;
          if (k_cnt == K_LAST) begin
            k_n     = '0;
            state_n = WRITE;
          end else begin
            k_n = k_cnt + KW'(1);
          end
        end
      end
      WRITE: begin
        push = !psum_full;
        if (push) begin
          acc_n = '0;
          if (o_cnt == O_LAST) begin
            o_n     = '0;
            state_n = DONE;
          end else begin
            o_n     = o_cnt + OW'(1);
            state_n = MAC;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      k_n     = '0;
      o_n     = '0;
      fire    = 1'b0;
      push    = 1'b0;
    end
  end

  // Output drive; pops and pushes are also suppressed while reset is asserted.
  always_comb begin
    ifmap_ren = fire && rstn;
    filt_ren  = fire && rstn;
    psum_wen  = push && rstn;
    psum_din  = acc;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Randomized and directed bench for pe_mac_ctrl with queue-based FIFO models
// and an arithmetic reference for the expected psums.
module tb_pe_mac_ctrl;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int FL = 3;
  localparam int NO = 2;
  localparam int RUN_LAT = NO * (FL + 1) + 1;

  logic          clk = 1'b0;
  logic          rstn, start, clear;
  logic          ifmap_empty, filt_empty, psum_full;
  logic [DW-1:0] ifmap_data, filt_data;
  logic          ifmap_ren, filt_ren, psum_wen, busy, done;
  logic [PW-1:0] psum_din;

  pe_mac_ctrl #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .FILT_LEN(FL), .NUM_OUT(NO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear),
    .ifmap_empty(ifmap_empty), .ifmap_data(ifmap_data), .ifmap_ren(ifmap_ren),
    .filt_empty(filt_empty), .filt_data(filt_data), .filt_ren(filt_ren),
    .psum_full(psum_full), .psum_wen(psum_wen), .psum_din(psum_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ifq[$], fq[$];
  logic [PW-1:0] got_q[$], exp_q[$], bp_din_q[$];

  int cyc_idx = 0;
  int start_cyc = -1000000;
  int restart_at = -100, clear_at = -100;
  int hf_from = -100, hf_len = 0, full_from = -100, full_len = 0;
  bit rnd = 1'b0;
  int viol, stall_ren, full_wen, pop_cnt, done_cnt, done_cyc;
  logic s_busy, s_done, s_ifren, s_fren, s_wen;
  logic [PW-1:0] s_din;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_pair(input int a, input int b);
    ifq.push_back(DW'(a));
    fq.push_back(DW'(b));
  endtask

  // Expected psums: plain signed sum of products, truncated to the psum width.
  task automatic build_expect();
    exp_q.delete();
    for (int o = 0; o < NO; o++) begin
      longint s;
      s = 0;
      for (int k = 0; k < FL; k++)
        s += longint'(signed'(ifq[o*FL+k])) * longint'(signed'(fq[o*FL+k]));
      exp_q.push_back(s[PW-1:0]);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, update the FIFO models at posedge.
  task automatic cyc();
    int rel;
    bit hf, hfull, hif;
    @(negedge clk);
    rel   = cyc_idx - start_cyc;
    hf    = (rel >= hf_from) && (rel < hf_from + hf_len);
    hfull = (rel >= full_from) && (rel < full_from + full_len);
    hif   = 1'b0;
    if (rnd) begin
      hif   = ($urandom_range(0, 3) == 0);
      hf    = ($urandom_range(0, 4) == 0);
      hfull = ($urandom_range(0, 2) == 0);
    end
    start       = (rel == 0) || (restart_at > 0 && rel == restart_at);
    clear       = (clear_at > 0 && rel == clear_at);
    ifmap_empty = (ifq.size() == 0) || hif;
    ifmap_data  = (ifq.size() != 0) ? ifq[0] : '0;
    filt_empty  = (fq.size() == 0) || hf;
    filt_data   = (fq.size() != 0) ? fq[0] : '0;
    psum_full   = hfull;
    #1;
    s_busy = busy; s_done = done; s_ifren = ifmap_ren; s_fren = filt_ren;
    s_wen = psum_wen; s_din = psum_din;
    if (s_ifren && ifmap_empty) viol++;
    if (s_fren && filt_empty) viol++;
    if (s_ifren != s_fren) viol++;
    if (s_wen && psum_full) viol++;
    if ((s_ifren || s_wen) && clear) viol++;
    if (s_done && !s_busy) viol++;
    if (hf && s_fren) stall_ren++;
    if (hfull && s_wen) full_wen++;
    if (hfull && s_busy && !rnd) bp_din_q.push_back(s_din);
    if (s_ifren) pop_cnt++;
    if (s_wen) got_q.push_back(s_din);
    if (s_done) begin
      done_cnt++;
      done_cyc = cyc_idx;
    end
    @(posedge clk);
    if (s_ifren && ifq.size() != 0) void'(ifq.pop_front());
    if (s_fren && fq.size() != 0) void'(fq.pop_front());
    cyc_idx++;
  endtask

  task automatic launch(input int budget, output bit timed_out);
    start_cyc = cyc_idx;
    got_q.delete(); bp_din_q.delete();
    viol = 0; stall_ren = 0; full_wen = 0; pop_cnt = 0; done_cnt = 0; done_cyc = -1;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (s_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input int exp_lat);
    check({tag, "_npush"}, got_q.size(), NO);
    for (int i = 0; i < NO && i < got_q.size(); i++)
      check($sformatf("%s_psum%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_ndone"}, done_cnt, 1);
    check({tag, "_npop"}, pop_cnt, NO * FL);
    check({tag, "_proto"}, viol, 0);
    if (exp_lat > 0) check({tag, "_lat"}, done_cyc - start_cyc, exp_lat);
  endtask

  task automatic reset_knobs();
    restart_at = -100; clear_at = -100; hf_from = -100; hf_len = 0;
    full_from = -100; full_len = 0; rnd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    rstn = 1'b0; start = 1'b0; clear = 1'b0;
    ifmap_empty = 1'b1; filt_empty = 1'b1; psum_full = 1'b0;
    ifmap_data = '0; filt_data = '0;
    push_pair(7, 7);
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_ren", s_ifren | s_fren, 0);
    check("rst_wen", s_wen, 0);
    check("rst_din", s_din, 0);
    ifq.delete(); fq.delete();

    // Basic run
    reset_knobs();
    push_pair(1, 1); push_pair(2, 1); push_pair(3, 1);
    push_pair(4, 2); push_pair(5, 2); push_pair(6, 2);
    build_expect();
    check("basic_ref0", exp_q[0], 6);
    check("basic_ref1", exp_q[1], 30);
    launch(50, to);
    check("basic_timeout", to, 0);
    check_run("basic", RUN_LAT);
    cyc();
    check("basic_idle_busy", s_busy, 0);

    // Signed values and wrap at the most negative input
    push_pair(-3, 4); push_pair(2, -5); push_pair(-1, -6);
    push_pair(-32768, -32768); push_pair(-32768, -32768); push_pair(-32768, -32768);
    build_expect();
    check("signed_ref0", exp_q[0], 32'hFFFFFFF0);
    check("signed_ref1", exp_q[1], 32'hC0000000);
    launch(50, to);
    check("signed_timeout", to, 0);
    check_run("signed", RUN_LAT);

    // Input stall mid-psum
    reset_knobs(); hf_from = 2; hf_len = 5;
    push_pair(1, 1); push_pair(2, 1); push_pair(3, 1);
    push_pair(4, 2); push_pair(5, 2); push_pair(6, 2);
    build_expect();
    launch(60, to);
    check("stall_timeout", to, 0);
    check_run("stall", RUN_LAT + 5);
    check("stall_ren", stall_ren, 0);

    // Back-pressure on the first write
    reset_knobs(); full_from = 4; full_len = 4;
    push_pair(9, -2); push_pair(8, 3); push_pair(-7, 4);
    push_pair(1, 1); push_pair(1, 1); push_pair(1, 1);
    build_expect();
    launch(60, to);
    check("bp_timeout", to, 0);
    check_run("bp", RUN_LAT + 4);
    check("bp_wen", full_wen, 0);
    check("bp_nheld", bp_din_q.size(), 4);
    for (int i = 0; i < bp_din_q.size(); i++)
      check($sformatf("bp_din_held%0d", i), bp_din_q[i], exp_q[0]);

    // Abort with clear at k_cnt=1 of psum 0
    reset_knobs(); clear_at = 2;
    push_pair(1, 1); push_pair(2, 1); push_pair(3, 1);
    push_pair(4, 2); push_pair(5, 2); push_pair(6, 2);
    launch(15, to);
    check("clr_no_done", done_cnt, 0);
    check("clr_no_push", got_q.size(), 0);
    check("clr_pops", pop_cnt, 1);
    check("clr_proto", viol, 0);
    check("clr_busy", s_busy, 0);
    ifq.delete(); fq.delete();
    reset_knobs();
    push_pair(2, 3); push_pair(-4, 5); push_pair(6, 7);
    push_pair(10, -10); push_pair(0, 99); push_pair(1, 1);
    build_expect();
    launch(50, to);
    check("clr_rerun_timeout", to, 0);
    check_run("clr_rerun", RUN_LAT);

    // Start pulsed while in MAC is ignored
    reset_knobs(); restart_at = 3;
    push_pair(1, 2); push_pair(3, 4); push_pair(5, 6);
    push_pair(7, 8); push_pair(9, 10); push_pair(11, 12);
    build_expect();
    launch(50, to);
    check("restart_timeout", to, 0);
    check_run("restart", RUN_LAT);
    for (int i = 0; i < 6; i++) cyc();
    check("restart_extra_done", done_cnt, 1);
    check("restart_extra_push", got_q.size(), NO);
    check("restart_idle", s_busy, 0);

    // Random data with random empty/full injection
    for (int r = 0; r < 6; r++) begin
      reset_knobs(); rnd = 1'b1;
      for (int i = 0; i < NO * FL; i++)
        push_pair(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      build_expect();
      launch(300, to);
      check($sformatf("rnd%0d_timeout", r), to, 0);
      check_run($sformatf("rnd%0d", r), 0);
      check($sformatf("rnd%0d_lat_min", r), (done_cyc - start_cyc) >= RUN_LAT, 1);
      ifq.delete(); fq.delete();
      rnd = 1'b0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
